reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  - 8 x 16-bit register file for the writeback stage; directly downstream of the 2:1 writeback mux.
//  - wdata is the mux output Y: ALU result or load data, chosen by S.
//  - Two combinational read ports feed the operand stage.
//  - A multi-cycle clear sequencer zeroes all registers one per cycle and reports busy/done.
// PARAMETERS
//  DATA_W    16  register / port data width (matches mux width)
//  ADDR_W    3   address width; NREGS = 2**ADDR_W (localparam, 8)
//  ZERO_REG  1   1: R0 hardwired to zero (writes ignored, reads 0); 0: R0 is ordinary
// PORTS
//  clk       in   1       rising-edge clock
//  rst_n     in   1       asynchronous active-low reset
//  we        in   1       write enable, sampled at posedge clk
//  waddr     in   ADDR_W  write address
//  wdata     in   DATA_W  write data (writeback mux output)
//  raddr_a   in   ADDR_W  read port A address
//  raddr_b   in   ADDR_W  read port B address
//  rdata_a   out  DATA_W  read port A data, combinational
//  rdata_b   out  DATA_W  read port B data, combinational
//  clr_req   in   1       request full clear, sampled at posedge clk
//  busy      out  1       high while clear sequence runs
//  clr_done  out  1       single-cycle pulse on clear completion
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active-low (rst_n).
//  - Reset state: all regs 0, busy 0, clr_done 0, FSM IDLE, clear index 0.
//  - Write: at posedge with we=1 and busy=0, regs[waddr] <= wdata.
//    - Write latency 1 cycle.
//    - waddr=0 with ZERO_REG=1: write dropped.
//  - Read: rdata_x = regs[raddr_x], purely combinational.
//    - Returns 0 when raddr_x=0 and ZERO_REG=1.
//  - FSM states IDLE -> CLEAR -> DONE -> IDLE:
//    - IDLE: clr_req=1 -> CLEAR, idx<=0.
//    - CLEAR: busy=1; each cycle regs[idx]<=0, idx++; idx==NREGS-1 -> DONE (NREGS cycles total).
//    - DONE: busy=0, clr_done=1 for exactly one cycle -> IDLE.
//  - During CLEAR: we is ignored (write lost, no stall); clr_req is ignored.
//    - Reads return current contents (partially cleared).
//  - we=1 and clr_req=1 together in IDLE: write commits on that edge; clear starts on the same edge and later zeroes it.
//  - clr_req held high through DONE: a new clear starts from IDLE on the next sampled edge.
//  - idx is ADDR_W bits wide, so it cannot wrap past NREGS-1.
//  - rst_n low mid-clear: immediate return to reset state; no clr_done pulse.
// CONFIGURATION
//  - Macro REG_FILE_BYPASS_EN defined: write-to-read forwarding.
//    - If we=1, busy=0, raddr_x==waddr and the write is not dropped (R0 rule), rdata_x = wdata combinationally.
//  - Macro not defined: no forwarding; rdata_x shows the old value until the edge after the write.
// STRUCTURE
//  - Package reg_file_pkg holds:
//    - DATA_W/ADDR_W defaults.
//    - typedef enum clr_state_t {IDLE, CLEAR, DONE}.
//    - typedef logic [DATA_W-1:0] word_t.
//  - Sub-module reg_file_clr_fsm: FSM + idx counter; outputs busy, clr_done, clr_we, clr_idx.
//  - Top level holds the storage array, write arbitration and read/bypass muxing.
// TESTING
//  - Reset: rst_n=0 -> every rdata 0, busy=0, clr_done=0; writes during reset have no effect.
//  - Write/read: we=1, waddr=3, wdata=16'hBEEF -> next cycle rdata_a(raddr_a=3)=16'hBEEF.
//    - Write waddr=0, wdata=16'h1234 -> rdata_b(raddr_b=0)=0 (ZERO_REG=1).
//  - Clear: fill R1..R7 with 16'hA5A5, pulse clr_req.
//    - busy=1 for exactly 8 cycles, then clr_done=1 for 1 cycle; all reads 0.
//    - we=1 to R5 mid-clear -> R5 stays 0.
//  - Simultaneous: idle, we=1, waddr=2, wdata=16'h00FF, clr_req=1 -> R2=16'h00FF for 2 cycles, then 0 after idx passes 2.
//  - Reset mid-clear: rst_n low on 4th busy cycle -> busy=0 immediately, no clr_done, all regs 0.
//  - Bypass: we=1, waddr=raddr_a=6, wdata=16'h5A5A.
//    - With REG_FILE_BYPASS_EN: rdata_a=16'h5A5A same cycle.
//    - Without: old value, then 16'h5A5A next cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Purpose : shared types and default widths for the writeback register file.
// Contents: DATA_W/ADDR_W defaults, clear-sequencer state enum, word/address types.
// Config  : none here; forwarding is selected in reg_file.sv by REG_FILE_BYPASS_EN.
package reg_file_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Purpose : clear sequencer; walks an index over every register, zeroing one per cycle.
// Latency : busy rises one edge after clr_req is sampled; 2**ADDR_W busy cycles, then a 1-cycle clr_done.
// Backpr. : none; clr_req is ignored while a clear is in progress or completing.
// Ports   : clk, rst_n (async active-low), clr_req in; busy, clr_done, clr_we, clr_idx out.
module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);

    // Last index to clear; the counter is exactly ADDR_W bits so it cannot overshoot.
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        busy     = 1'b0;
        clr_done = 1'b0;
        clr_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // clr_req is not sampled here; a held request restarts from IDLE.
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign clr_idx = idx_q;

endmodule

// File: rtl/reg_file.sv
// Purpose : 2**ADDR_W x DATA_W writeback register file, two combinational read ports, sequenced clear.
// Latency : write visible on reads one cycle after the edge (same cycle when REG_FILE_BYPASS_EN is defined).
// Backpr. : none; writes presented while busy are dropped, not stalled.
// Ports   : clk, rst_n; we/waddr/wdata write port; raddr_a/rdata_a, raddr_b/rdata_b read ports;
//           clr_req in, busy/clr_done out.
// Config  : define REG_FILE_BYPASS_EN for write-to-read forwarding. ZERO_REG=1 hardwires R0 to zero.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_en;

    reg_file_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    // A write commits only when no clear is running and it does not target a hardwired R0.
    assign wr_en = we && !busy && !(ZERO_REG && (waddr == '0));

    always_comb begin
        regs_d = regs_q;
        if (clr_we) begin
            regs_d[clr_idx] = '0;
        end else if (wr_en) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // wr_en already excludes R0, so forwarding never leaks data onto a zero register.
    always_comb begin
        rdata_a = regs_q[raddr_a];
        if (ZERO_REG && (raddr_a == '0)) begin
            rdata_a = '0;
        end
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
`endif
    end

    always_comb begin
        rdata_b = regs_q[raddr_b];
        if (ZERO_REG && (raddr_b == '0)) begin
            rdata_b = '0;
        end
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// Purpose : self-checking bench for reg_file: directed vector table plus clear/reset/bypass sequences.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic        clr_req;
    logic        busy;
    logic        clr_done;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic [2:0]  raddr_a;
        logic [2:0]  raddr_b;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic check_all(input string name, input logic [15:0] exp);
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i);
            #1;
            check(name, rdata_a, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected end earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic saw_done;

        vecs[0] = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b1, 3'd0, 16'h1234, 3'd3, 3'd0, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b1, 3'd1, 16'h1111, 3'd1, 3'd3, 16'h1111, 16'hBEEF};
        vecs[3] = '{1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd1, 16'hFFFF, 16'h1111};
        vecs[4] = '{1'b0, 3'd7, 16'h0000, 3'd7, 3'd7, 16'hFFFF, 16'hFFFF};
        vecs[5] = '{1'b1, 3'd3, 16'h0001, 3'd3, 3'd7, 16'h0001, 16'hFFFF};

        // Reset with a write attempted during it.
        rst_n   = 1'b0;
        we      = 1'b1;
        waddr   = 3'd3;
        wdata   = 16'hDEAD;
        raddr_a = 3'd3;
        raddr_b = 3'd3;
        clr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata_a", rdata_a, 16'h0000);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_clr_done", {15'd0, clr_done}, 16'd0);
        we    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset_reg", 16'h0000);

        // Table-driven write/read vectors.
        for (int i = 0; i < 6; i++) begin
            we      = vecs[i].we;
            waddr   = vecs[i].waddr;
            wdata   = vecs[i].wdata;
            raddr_a = vecs[i].raddr_a;
            raddr_b = vecs[i].raddr_b;
            @(posedge clk);
            #1;
            we = 1'b0;
            #1;
            check($sformatf("vec%0d_a", i), rdata_a, vecs[i].exp_a);
            check($sformatf("vec%0d_b", i), rdata_b, vecs[i].exp_b);
        end

        // Clear sequence: fill R1..R7, clear, attempt a write to R5 after it is cleared.
        for (int r = 1; r < 8; r++) wr(3'(r), 16'hA5A5);
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        cnt = 0;
        while (busy && cnt < 20) begin
            if (cnt == 6) begin
                we    = 1'b1;
                waddr = 3'd5;
                wdata = 16'hFFFF;
            end
            @(posedge clk);
            #1;
            we = 1'b0;
            cnt++;
        end
        check("clear_busy_cycles", 16'(cnt), 16'd8);
        check("clear_done_pulse", {15'd0, clr_done}, 16'd1);
        @(posedge clk);
        #1;
        check("clear_done_single", {15'd0, clr_done}, 16'd0);
        check_all("cleared_reg", 16'h0000);

        // Write and clear requested on the same edge.
        we      = 1'b1;
        waddr   = 3'd2;
        wdata   = 16'h00FF;
        clr_req = 1'b1;
        raddr_a = 3'd2;
        @(posedge clk);
        #1;
        we      = 1'b0;
        clr_req = 1'b0;
        check("simul_commit", rdata_a, 16'h00FF);
        check("simul_busy", {15'd0, busy}, 16'd1);
        @(posedge clk);
        #1;
        check("simul_hold1", rdata_a, 16'h00FF);
        @(posedge clk);
        #1;
        check("simul_hold2", rdata_a, 16'h00FF);
        @(posedge clk);
        #1;
        check("simul_cleared", rdata_a, 16'h0000);
        cnt = 0;
        while (busy && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("simul_finish", {15'd0, busy}, 16'd0);
        @(posedge clk);
        #1;

        // Reset asserted on the 4th busy cycle.
        for (int r = 1; r < 8; r++) wr(3'(r), 16'h3C3C);
        clr_req = 1'b1;
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("midclr_busy_before", {15'd0, busy}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("midclr_busy_after", {15'd0, busy}, 16'd0);
        check("midclr_done_after", {15'd0, clr_done}, 16'd0);
        check_all("midclr_reg", 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (clr_done) saw_done = 1'b1;
        end
        check("midclr_no_done", {15'd0, saw_done}, 16'd0);

        // Forwarding behaviour.
        wr(3'd6, 16'h1111);
        we      = 1'b1;
        waddr   = 3'd6;
        wdata   = 16'h5A5A;
        raddr_a = 3'd6;
        raddr_b = 3'd0;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("bypass_same_cycle", rdata_a, 16'h5A5A);
`else
        check("bypass_same_cycle", rdata_a, 16'h1111);
`endif
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        check("bypass_next_cycle", rdata_a, 16'h5A5A);
        we    = 1'b1;
        waddr = 3'd0;
        wdata = 16'h7777;
        #1;
        check("bypass_r0", rdata_b, 16'h0000);
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        check("r0_after_write", rdata_b, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
